elevador_planta: RTL and testbench

Behavioural/synthesizable model of the 3-floor elevator shaft: the plant side of the motor/sensor interface. Consumes motor commands `mup`/`mdw` from the elevator controller and produces floor sensors `f1`/`f2`/`f3` from an internal cab-position counter. It is used on the board in place of real hardware and in benches as the controller's responder. It detects end-of-shaft crashes and conflicting motor commands.

---
 rtl/elevador_pkg.sv | 49 ++++
 rtl/elevador_planta_if.sv | 52 +++++
 rtl/planta_tick_gen.sv | 47 ++++
 rtl/elevador_planta.sv | 174 +++++++++++++++++
 tb/tb_elevador_planta.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/elevador_pkg.sv
// ---------------------------------------------------------------------------
// elevador_pkg
// Shared definitions for the 3-floor elevator shaft plant model.
//   - planta_state_t : plant FSM states (IDLE / UP / DOWN / CRASH)
//   - fault_sel_t    : sensor stuck-at-1 fault selector encodings
//   - NUM_FLOORS     : number of floors served by the shaft
//   - floor_pos()    : position of floor k given the shaft geometry
//   - pos_max()      : highest legal cab position
//   - pos_width()    : bits needed to hold 0..pos_max()
//   - in_window()    : floor sensor window test
// ---------------------------------------------------------------------------
package elevador_pkg;

  localparam int NUM_FLOORS = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_UP    = 2'd1,
    ST_DOWN  = 2'd2,
    ST_CRASH = 2'd3
  } planta_state_t;

  typedef enum logic [1:0] {
    FAULT_NONE = 2'b00,
    FAULT_F1   = 2'b01,
    FAULT_F2   = 2'b10,
    FAULT_F3   = 2'b11
  } fault_sel_t;

  // Floor k (1-based) sits one sensor half-window above the bottom of the
  // shaft plus (k-1) floor spacings.
  function automatic int floor_pos(input int k, input int spf, input int win);
    return win + (k - 32'sd1) * spf;
  endfunction

  // The shaft extends one sensor half-window beyond the outer floors.
  function automatic int pos_max(input int spf, input int win);
    return 32'sd2 * spf + 32'sd2 * win;
  endfunction

  function automatic int pos_width(input int spf, input int win);
    return $clog2(pos_max(spf, win) + 32'sd1);
  endfunction

  function automatic bit in_window(input int p, input int fl, input int win);
    return (p >= fl - win) && (p <= fl + win);
  endfunction

endpackage

// File: rtl/elevador_planta_if.sv
// ---------------------------------------------------------------------------
// elevador_planta_if
// Motor/sensor bus between the elevator controller (master) and the shaft
// plant (slave).
//   mup, mdw           : motor up / down commands (master -> slave)
//   fault_sel [1:0]    : sensor fault injection, only with
//                        ELEVADOR_PLANTA_FAULT_EN defined (master -> slave)
//   f1, f2, f3         : floor sensors (slave -> master)
//   pos [PW-1:0]       : cab position (slave -> master)
//   moving, crash,
//   conflict           : plant status (slave -> master)
// ---------------------------------------------------------------------------
interface elevador_planta_if #(
  parameter int PW = elevador_pkg::pos_width(16, 2)
) ();

  logic          mup;
  logic          mdw;
`ifdef ELEVADOR_PLANTA_FAULT_EN
  logic [1:0]    fault_sel;
`endif
  logic          f1;
  logic          f2;
  logic          f3;
  logic [PW-1:0] pos;
  logic          moving;
  logic          crash;
  logic          conflict;

`ifdef ELEVADOR_PLANTA_FAULT_EN
  modport master (
    output mup, mdw, fault_sel,
    input  f1, f2, f3, pos, moving, crash, conflict
  );

  modport slave (
    input  mup, mdw, fault_sel,
    output f1, f2, f3, pos, moving, crash, conflict
  );
`else
  modport master (
    output mup, mdw,
    input  f1, f2, f3, pos, moving, crash, conflict
  );

  modport slave (
    input  mup, mdw,
    output f1, f2, f3, pos, moving, crash, conflict
  );
`endif

endinterface

// File: rtl/planta_tick_gen.sv
// ---------------------------------------------------------------------------
// planta_tick_gen
// Step prescaler for the shaft plant. Counts 0..PRESCALE-1 while enabled and
// wraps; clear has priority and returns the count to 0.
//   clk    : clock
//   reset  : synchronous, active-low
//   clear  : force count to 0 on the next edge
//   en     : advance count on the next edge
//   tick   : count is at its last value (a step is due on the next edge)
// ---------------------------------------------------------------------------
module planta_tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_r;

  // Prescaler count register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r <= {CW{1'b0}};
    end else if (clear) begin
      cnt_r <= {CW{1'b0}};
    end else if (en) begin
      if (cnt_r == LAST) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Not gated by en: the step due at the last count must still land on the
  // edge where the command is released or reversed.
  assign tick = (cnt_r == LAST);

endmodule

// File: rtl/elevador_planta.sv
// ---------------------------------------------------------------------------
// elevador_planta
// Plant model of a 3-floor elevator shaft. Motor commands move an internal
// cab-position counter one unit every PRESCALE cycles; floor sensors are
// derived from the position. Running past either end of the shaft latches a
// crash until reset; both motor commands at once are flagged as a conflict.
//
// Parameters: PRESCALE (cycles per step, >=1), STEPS_PER_FLOOR,
//             SENSOR_WIN (sensor half-width), INIT_FLOOR (1..3).
// Ports:
//   clk    : clock
//   reset  : synchronous, active-low
//   bus    : elevador_planta_if.slave (mup/mdw in; f1..f3, pos, moving,
//            crash, conflict out, all registered)
// Build option: ELEVADOR_PLANTA_FAULT_EN adds bus.fault_sel, which forces
//   one floor sensor to stuck-at-1 (sampled every cycle, ignores reset).
// ---------------------------------------------------------------------------
module elevador_planta
  import elevador_pkg::*;
#(
  parameter int PRESCALE        = 4,
  parameter int STEPS_PER_FLOOR = 16,
  parameter int SENSOR_WIN      = 2,
  parameter int INIT_FLOOR      = 1
) (
  input  logic         clk,
  input  logic         reset,
  elevador_planta_if.slave bus
);

  localparam int POS_MAX = pos_max(STEPS_PER_FLOOR, SENSOR_WIN);
  localparam int PW      = pos_width(STEPS_PER_FLOOR, SENSOR_WIN);

  localparam logic [PW-1:0] POS_MAX_V = PW'(POS_MAX);
  localparam logic [PW-1:0] POS_INIT_V =
    PW'(floor_pos(INIT_FLOOR, STEPS_PER_FLOOR, SENSOR_WIN));
  localparam logic [NUM_FLOORS-1:0] SENS_INIT_V =
    (INIT_FLOOR == 3) ? 3'b100 : ((INIT_FLOOR == 2) ? 3'b010 : 3'b001);

  planta_state_t         state_r;
  logic [PW-1:0]         pos_r;
  logic                  crash_r;
  logic                  conflict_r;
  logic                  moving_r;
  logic [NUM_FLOORS-1:0] sens_r;

  planta_state_t         cmd_state_s;
  planta_state_t         state_next_s;
  logic                  both_s;
  logic                  active_s;
  logic                  hold_dir_s;
  logic                  tick_s;
  logic                  step_s;
  logic                  crash_now_s;
  logic [PW-1:0]         pos_next_s;
  logic [NUM_FLOORS-1:0] sens_s;
  logic [NUM_FLOORS-1:0] fault_mask_s;

  // Decode the motor command pair into the requested state.
  always_comb begin
    cmd_state_s = ST_IDLE;
    case ({bus.mup, bus.mdw})
      2'b10:   cmd_state_s = ST_UP;
      2'b01:   cmd_state_s = ST_DOWN;
      default: cmd_state_s = ST_IDLE;
    endcase
    both_s = bus.mup & bus.mdw;
  end

  // The prescaler keeps counting only while the same direction is held;
  // entering IDLE, reversing, or crashing restarts it from zero.
  always_comb begin
    active_s   = (state_r == ST_UP) || (state_r == ST_DOWN);
    hold_dir_s = active_s && (cmd_state_s == state_r);
  end

  planta_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clear (!hold_dir_s),
    .en    (hold_dir_s),
    .tick  (tick_s)
  );

  // Step evaluation: apply a legal step or detect an end-of-shaft crash.
  always_comb begin
    step_s      = active_s && tick_s;
    crash_now_s = 1'b0;
    pos_next_s  = pos_r;
    if (step_s) begin
      if (state_r == ST_UP) begin
        if (pos_r == POS_MAX_V) begin
          crash_now_s = 1'b1;
        end else begin
          pos_next_s = pos_r + PW'(1);
        end
      end else begin
        if (pos_r == {PW{1'b0}}) begin
          crash_now_s = 1'b1;
        end else begin
          pos_next_s = pos_r - PW'(1);
        end
      end
    end else begin
      pos_next_s = pos_r;
    end
  end

  // Next state: CRASH is absorbing; otherwise follow the sampled command.
  always_comb begin
    state_next_s = cmd_state_s;
    if (state_r == ST_CRASH) begin
      state_next_s = ST_CRASH;
    end else if (crash_now_s) begin
      state_next_s = ST_CRASH;
    end else begin
      state_next_s = cmd_state_s;
    end
  end

  // Floor sensor windows around each floor, computed from the current pos.
  always_comb begin
    sens_s = {NUM_FLOORS{1'b0}};
    for (int k = 0; k < NUM_FLOORS; k++) begin
      sens_s[k] = in_window(int'(pos_r),
                            floor_pos(k + 32'sd1, STEPS_PER_FLOOR, SENSOR_WIN),
                            SENSOR_WIN);
    end
  end

  // Optional stuck-at-1 sensor fault injection.
  always_comb begin
    fault_mask_s = {NUM_FLOORS{1'b0}};
`ifdef ELEVADOR_PLANTA_FAULT_EN
    case (fault_sel_t'(bus.fault_sel))
      FAULT_F1: fault_mask_s = 3'b001;
      FAULT_F2: fault_mask_s = 3'b010;
      FAULT_F3: fault_mask_s = 3'b100;
      default:  fault_mask_s = 3'b000;
    endcase
`endif
  end

  // Plant FSM, position and registered status/sensor outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      pos_r      <= POS_INIT_V;
      crash_r    <= 1'b0;
      conflict_r <= 1'b0;
      moving_r   <= 1'b0;
      sens_r     <= SENS_INIT_V;
    end else begin
      state_r    <= state_next_s;
      pos_r      <= pos_next_s;
      crash_r    <= crash_r | crash_now_s;
      // Commands are ignored once crashed, so no conflict is reported there.
      conflict_r <= both_s && (state_r != ST_CRASH) && !crash_now_s;
      moving_r   <= (state_next_s == ST_UP) || (state_next_s == ST_DOWN);
      sens_r     <= sens_s | fault_mask_s;
    end
  end

  assign bus.pos      = pos_r;
  assign bus.f1       = sens_r[0];
  assign bus.f2       = sens_r[1];
  assign bus.f3       = sens_r[2];
  assign bus.moving   = moving_r;
  assign bus.crash    = crash_r;
  assign bus.conflict = conflict_r;

endmodule

// File: tb/tb_elevador_planta.sv
// ---------------------------------------------------------------------------
// tb_elevador_planta
// Scoreboard bench for elevador_planta. The driver applies one command per
// cycle and pushes the expected post-edge outputs, computed by a run-length
// model of the shaft, into a queue; a monitor pops and compares every cycle.
// ---------------------------------------------------------------------------
module tb_elevador_planta;
  import elevador_pkg::*;

  localparam int P     = 4;
  localparam int SPF   = 16;
  localparam int WIN   = 2;
  localparam int INIT  = 1;
  localparam int PMAX  = 2 * SPF + 2 * WIN;
  localparam int PWID  = $clog2(PMAX + 1);
`ifdef ELEVADOR_PLANTA_FAULT_EN
  localparam bit FAULT_BUILD = 1'b1;
`else
  localparam bit FAULT_BUILD = 1'b0;
`endif

  typedef struct {
    int       pos;
    bit [2:0] f;
    bit       moving;
    bit       crash;
    bit       conflict;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  elevador_planta_if #(.PW(PWID)) bus ();

  elevador_planta #(
    .PRESCALE        (P),
    .STEPS_PER_FLOOR (SPF),
    .SENSOR_WIN      (WIN),
    .INIT_FLOOR      (INIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: position, crash latch, current command run.
  int       m_pos;
  bit       m_crash;
  int       run_dir;   // 0 none, 1 up, 2 down
  int       run_len;   // consecutive edges that sampled run_dir
  bit [2:0] m_f;
  bit       m_moving;
  bit       m_conflict;

  function automatic int fl(input int k);
    return WIN + (k - 1) * SPF;
  endfunction

  function automatic bit [2:0] sens_of(input int p);
    bit [2:0] s;
    s = 3'b000;
    for (int k = 1; k <= 3; k++) begin
      int d;
      d = p - fl(k);
      if (d < 0) d = -d;
      s[k-1] = (d <= WIN);
    end
    return s;
  endfunction

  // Model of one clock edge with the given sampled inputs.
  task automatic model_edge(input bit u, input bit d, input bit rn, input bit [1:0] fs);
    bit [2:0] mask;
    int       cmd;
    int       tgt;
    bit       crashed_now;
    mask = (fs == 2'd0) ? 3'b000 : (3'b001 << (fs - 2'd1));
    if (!rn) begin
      m_pos = fl(INIT); m_crash = 1'b0; run_dir = 0; run_len = 0;
      m_f = sens_of(fl(INIT)); m_moving = 1'b0; m_conflict = 1'b0;
    end else begin
      m_f = sens_of(m_pos) | mask;
      if (m_crash) begin
        m_moving = 1'b0; m_conflict = 1'b0;
      end else begin
        crashed_now = 1'b0;
        if (run_dir != 0 && run_len > 0 && (run_len % P) == 0) begin
          tgt = m_pos + ((run_dir == 1) ? 1 : -1);
          if (tgt < 0 || tgt > PMAX) begin
            m_crash = 1'b1; crashed_now = 1'b1;
          end else begin
            m_pos = tgt;
          end
        end
        cmd = (u && !d) ? 1 : ((d && !u) ? 2 : 0);
        m_conflict = u && d && !crashed_now;
        if (crashed_now) begin
          run_dir = 0; run_len = 0; m_moving = 1'b0;
        end else begin
          if (cmd != 0 && cmd == run_dir) begin
            run_len = run_len + 1;
          end else begin
            run_dir = cmd; run_len = (cmd != 0) ? 1 : 0;
          end
          m_moving = (cmd != 0);
        end
      end
    end
    exp_q.push_back('{pos: m_pos, f: m_f, moving: m_moving,
                      crash: m_crash, conflict: m_conflict});
  endtask

  // Drive one cycle of stimulus shortly after the edge and predict the next.
  task automatic drive(input bit u, input bit d, input bit rn, input bit [1:0] fs);
    bit [1:0] fs_eff;
    @(posedge clk);
    #2;
    fs_eff = fs & {2{FAULT_BUILD}};
    reset   = rn;
    bus.mup = u;
    bus.mdw = d;
`ifdef ELEVADOR_PLANTA_FAULT_EN
    bus.fault_sel = fs_eff;
`endif
    model_edge(u, d, rn, fs_eff);
  endtask

  task automatic hold(input bit u, input bit d, input int n);
    for (int i = 0; i < n; i++) drive(u, d, 1'b1, 2'b00);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks = checks + 1;
    if (act != expv) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: every cycle, compare the DUT against the oldest prediction.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pos",      int'(bus.pos),      e.pos);
        chk("f1",       int'(bus.f1),       int'(e.f[0]));
        chk("f2",       int'(bus.f2),       int'(e.f[1]));
        chk("f3",       int'(bus.f3),       int'(e.f[2]));
        chk("moving",   int'(bus.moving),   int'(e.moving));
        chk("crash",    int'(bus.crash),    int'(e.crash));
        chk("conflict", int'(bus.conflict), int'(e.conflict));
      end
    end
  end

  initial begin : stimulus
    reset   = 1'b0;
    bus.mup = 1'b0;
    bus.mdw = 1'b0;
`ifdef ELEVADOR_PLANTA_FAULT_EN
    bus.fault_sel = 2'b00;
`endif
    m_pos = fl(INIT); m_crash = 1'b0; run_dir = 0; run_len = 0;
    m_f = sens_of(fl(INIT)); m_moving = 1'b0; m_conflict = 1'b0;

    // Reset, then travel floor 1 -> floor 2 and stop there.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 2'b00);
    hold(1'b1, 1'b0, 64);
    hold(1'b0, 1'b0, 4);
    // Short pulse cancels the step; both-high reports conflict.
    hold(1'b1, 1'b0, 3);
    hold(1'b0, 1'b0, 3);
    hold(1'b1, 1'b1, 5);
    hold(1'b0, 1'b0, 2);
    // Reverse mid-travel at cnt=2.
    hold(1'b1, 1'b0, 3);
    hold(1'b0, 1'b1, 9);
    hold(1'b0, 1'b0, 2);
    // Run into the top of the shaft, then try to back out.
    hold(1'b1, 1'b0, 100);
    hold(1'b0, 1'b1, 10);
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 1'b0, 2'b00);
    hold(1'b0, 1'b0, 2);
    // Stuck-at-1 on f3 while parked on floor 1.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 2'b11);
    hold(1'b0, 1'b0, 2);
    // Hold-exactly-PRESCALE then release: the due step still lands.
    hold(1'b1, 1'b0, P);
    hold(1'b0, 1'b0, 3);

    // Randomized command runs with occasional resets and faults.
    for (int r = 0; r < 90; r++) begin
      int       len;
      int       c;
      bit       u;
      bit       d;
      bit [1:0] fs;
      len = $urandom_range(1, 14);
      c   = $urandom_range(0, 9);
      u   = (c < 4) || (c == 8);
      d   = ((c >= 4) && (c < 8)) || (c == 8);
      fs  = ((r % 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      for (int i = 0; i < len; i++) drive(u, d, 1'b1, fs);
      if ($urandom_range(0, 11) == 0) drive(1'b0, 1'b0, 1'b0, 2'b00);
    end

    // Let the monitor consume the last prediction, bounded.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
